// File: rtl/prog_loader.sv
// Program-memory loader: LEN_HI, LEN_LO, N bytes[, CHK] -> 4096x8 writes; mem_we lags the transfer by 1 cycle.
// in_ready is high only while a load is in progress; CHECKSUM_EN adds the trailing checksum byte and err.
module prog_loader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_byte,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int HI_W = ADDR_W - DATA_W;
    localparam logic [ADDR_W-1:0] L_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_DONE
`ifdef CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_xfer;
    logic              w_last;
    logic              w_start_ok;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_addr;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;
`ifdef CHECKSUM_EN
    logic [DATA_W-1:0] r_sum;
    logic              r_err;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        w_start_ok = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_start_ok = 1'b1;
                if (start) w_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) w_next = S_DATA;
            end
            S_DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && w_last) begin
`ifdef CHECKSUM_EN
                    w_next = S_CHK;
`else
                    w_next = S_DONE;
`endif
                end
            end
`ifdef CHECKSUM_EN
            S_CHK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) w_next = S_DONE;
            end
`endif
            S_DONE: begin
                done       = 1'b1;
                w_start_ok = 1'b1;
                if (start) w_next = S_LEN_HI;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_xfer = in_valid && in_ready;
    // The counter stops on the final byte so a 4096-byte image never revisits address 0.
    assign w_last = (r_addr == r_len);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len      <= '0;
            r_addr     <= '0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
`ifdef CHECKSUM_EN
            r_sum      <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            if (w_start_ok && start) begin
                r_addr <= '0;
`ifdef CHECKSUM_EN
                r_sum  <= '0;
                r_err  <= 1'b0;
`endif
            end
            if (w_xfer) begin
                case (r_state)
                    S_LEN_HI: r_len[ADDR_W-1:DATA_W] <= in_byte[HI_W-1:0];
                    S_LEN_LO: begin
                        r_len[DATA_W-1:0] <= in_byte;
                        r_addr            <= '0;
                    end
                    S_DATA: begin
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= r_addr;
                        r_mem_data <= in_byte;
`ifdef CHECKSUM_EN
                        r_sum      <= r_sum + in_byte;
`endif
                        if (!w_last) r_addr <= r_addr + L_ONE;
                    end
`ifdef CHECKSUM_EN
                    S_CHK: r_err <= (in_byte != r_sum);
`endif
                    default: ;
                endcase
            end
        end
    end

    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_data = r_mem_data;
`ifdef CHECKSUM_EN
    assign err = r_err;
`else
    assign err = 1'b0;
`endif
    assign cpu_reset = !((r_state == S_DONE) && !err);

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes queued as bytes are driven, matched as mem_we fires.
module tb_prog_loader;
    logic        clk = 1'b0;
    logic        reset, start, in_valid;
    logic [7:0]  in_byte;
    logic        in_ready, mem_we, cpu_reset, busy, done, err;
    logic [11:0] mem_addr;
    logic [7:0]  mem_data;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [19:0] exp_q[$];
    logic [19:0] mon_exp;
    logic [7:0]  d[$];

    prog_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we !== 1'b0) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_write", {11'b0, mem_we, mem_addr, mem_data}, 32'h0);
            end else begin
                mon_exp = exp_q.pop_front();
                check_eq("write", {12'b0, mem_addr, mem_data}, {12'b0, mon_exp});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        logic rdy;
        int   tmo;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                in_valid = 1'b0;
                in_byte  = 8'($urandom);
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_byte  = b;
        tmo      = 0;
        forever begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            tmo++;
            if (tmo > 50) begin
                check_eq("xfer_timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic load(input logic [7:0] data[$], input logic [3:0] hi_junk,
                        input bit chk_good, input bit gaps, input bit noise);
        int          n;
        logic [11:0] len;
        logic [7:0]  sum;
        logic        exp_err;
        n   = data.size();
        len = 12'(n - 1);
        sum = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("busy_after_start", {31'b0, busy}, 1);
        send_byte({hi_junk, len[11:8]}, gaps);
        send_byte(len[7:0], gaps);
        if (noise) start = 1'b1;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({12'(i), data[i]});
            sum = sum + data[i];
            if (i == n - 1) begin
                start = 1'b0;
                check_eq("cpu_reset_before_last", {31'b0, cpu_reset}, 1);
            end
            send_byte(data[i], gaps);
        end
`ifdef CHECKSUM_EN
        exp_err = !chk_good;
        check_eq("done_before_chk", {31'b0, done}, 0);
        check_eq("cpu_reset_before_chk", {31'b0, cpu_reset}, 1);
        send_byte(chk_good ? sum : ~sum, gaps);
`else
        exp_err = 1'b0;
`endif
        check_eq("done", {31'b0, done}, 1);
        check_eq("err", {31'b0, err}, {31'b0, exp_err});
        check_eq("cpu_reset_done", {31'b0, cpu_reset}, {31'b0, exp_err});
        check_eq("busy_done", {31'b0, busy}, 0);
        check_eq("in_ready_done", {31'b0, in_ready}, 0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("queue_drained", exp_q.size(), 0);
        check_eq("hold_addr", {20'b0, mem_addr}, {20'b0, len});
        check_eq("hold_data", {24'b0, mem_data}, {24'b0, data[n-1]});
    endtask

    task automatic idle_noise();
        in_valid = 1'b1;
        in_byte  = 8'hEE;
        repeat (4) begin
            @(negedge clk);
            check_eq("in_ready_idle", {31'b0, in_ready}, 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout observed %0t expected finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b1; in_valid = 1'b0; in_byte = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", {31'b0, in_ready}, 0);
        check_eq("rst_mem_we", {31'b0, mem_we}, 0);
        check_eq("rst_mem_addr", {20'b0, mem_addr}, 0);
        check_eq("rst_mem_data", {24'b0, mem_data}, 0);
        check_eq("rst_cpu_reset", {31'b0, cpu_reset}, 1);
        check_eq("rst_busy", {31'b0, busy}, 0);
        check_eq("rst_done", {31'b0, done}, 0);
        check_eq("rst_err", {31'b0, err}, 0);
        reset = 1'b0; start = 1'b0;
        @(posedge clk);
        #1;
        check_eq("idle_busy", {31'b0, busy}, 0);

        // Basic three-byte image.
        d = '{8'hA1, 8'hB2, 8'hC3};
        load(d, 4'h0, 1'b1, 1'b0, 1'b0);
`ifdef CHECKSUM_EN
        // Bad checksum, then a clean reload clears err.
        load(d, 4'h0, 1'b0, 1'b0, 1'b0);
        idle_noise();
        load(d, 4'h0, 1'b1, 1'b0, 1'b0);
`endif
        // Host gaps plus start held during the data phase.
        load(d, 4'h0, 1'b1, 1'b1, 1'b1);

        // Single-byte image with junk in LEN_HI's upper nibble.
        d = '{8'h5A};
        load(d, 4'hA, 1'b1, 1'b0, 1'b0);

        // Reset after the second data byte.
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        exp_q.push_back({12'd0, 8'hA1});
        send_byte(8'hA1, 1'b0);
        exp_q.push_back({12'd1, 8'hB2});
        send_byte(8'hB2, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("midrst_busy", {31'b0, busy}, 0);
        check_eq("midrst_mem_we", {31'b0, mem_we}, 0);
        check_eq("midrst_cpu_reset", {31'b0, cpu_reset}, 1);
        check_eq("midrst_done", {31'b0, done}, 0);
        check_eq("midrst_queue", exp_q.size(), 0);
        idle_noise();
        check_eq("idle_after_noise", {31'b0, busy}, 0);
        d = '{8'hA1, 8'hB2, 8'hC3};
        load(d, 4'h0, 1'b1, 1'b0, 1'b0);

        // Full 4096-byte image of constant data, back-to-back transfers.
        d.delete();
        for (int i = 0; i < 4096; i++) d.push_back(8'h01);
        load(d, 4'h0, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
